fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage for the pipelined LEGv8 core. It owns the PC, drives a synchronous-read instruction memory with one cycle of read latency, and holds the IF/ID pipeline register. The IF/ID register supplies `instr_d` to decode: sign extension, register file and control. The block absorbs decode stalls without losing or duplicating instructions, and flushes on a taken branch.

## Interface
Parameters:
- `PC_RESET`, default 64'h0: PC of the first fetch after reset.
- `ADDR_W`, default 6: word-address width of the instruction memory.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `reset` in 1: reset, asynchronous and active-low.
- `imem_en` out 1: read request this cycle.
- `imem_addr` out ADDR_W: word address, equal to `fetch_pc[ADDR_W+1:2]`.
- `imem_rdata` in 32: read data. Valid in the cycle after a request is sampled.
- `stall_d` in 1: decode cannot accept a new instruction. Hold IF/ID.
- `redirect` in 1: taken branch or jump. Flush and refetch.
- `redirect_pc` in 64: branch target. Bits [1:0] are ignored.
- `instr_d` out 32: IF/ID instruction.
- `pc_d` out 64: PC of `instr_d`.
- `valid_d` out 1: `instr_d` is a real instruction. When 0, `instr_d` is a bubble.

## Operation
Registers:
- `pc_f`: next sequential PC.
- `req_valid`, `req_pc`: request in flight.
- `hold_valid`, `hold_instr`, `hold_pc`: one-entry hold buffer.
- IF/ID: `valid_d`, `instr_d`, `pc_d`.

Reset state:
- `pc_f`=PC_RESET, `req_valid`=0, `hold_valid`=0, `valid_d`=0, `instr_d`=32'h0, `pc_d`=64'h0.
- While `reset` is low, `imem_en`=0.

Combinational:
- `issue` = `reset` & (`redirect` | ~`stall_d`).
- `fetch_pc` = `redirect` ? {`redirect_pc[63:2]`, 2'b00} : `pc_f`.
- `imem_en` = `issue`.

Per-cycle update:
- Always: `req_valid` <= `issue`.
- If `issue`: `req_pc` <= `fetch_pc` and `pc_f` <= `fetch_pc` + 4, modulo 2^64, wrapping silently.
- `redirect`=1 has highest priority:
  - `valid_d` <= 0 and `hold_valid` <= 0.
  - Any response returning this cycle is discarded.
  - `stall_d` is overridden.
- Else if `stall_d`=1:
  - IF/ID holds all three fields.
  - If `req_valid` & ~`hold_valid`, capture into the hold buffer: `hold_instr` <= `imem_rdata`, `hold_pc` <= `req_pc`, `hold_valid` <= 1.
- Else, when not stalled:
  - If `hold_valid`: IF/ID <= hold buffer, and `hold_valid` <= 0.
  - Otherwise: IF/ID <= {`req_valid`, `imem_rdata`, `req_pc`}.
  - When `req_valid`=0, load `instr_d` as 32'h0.
- Invariant: at most one response is outstanding while stalled. A response arriving while `hold_valid`=1 is impossible. The bench asserts this.

## Timing
- First instruction after reset release: request in cycle 0. `valid_d`=1 with `pc_d`=PC_RESET after the edge ending cycle 1, giving 2-cycle latency.
- Steady state without stalls: one instruction per cycle, `pc_d` advancing by 4.
- Stall asserted for N cycles:
  - `imem_en` is 0 on every stall cycle.
  - `instr_d` and `pc_d` are stable.
  - On release, the held instruction enters IF/ID on the first edge. The next instruction follows on the next edge, with no bubble and no duplicate.
- Redirect asserted in cycle R:
  - `valid_d`=0 after edge R.
  - The target appears after edge R+1 if `stall_d`=0 in cycle R+1.
  - If stalled, the target waits in the hold buffer.
- Redirect asserted for consecutive cycles: the last target wins.
- Asynchronous reset mid-stream: all registers return to reset values immediately, without waiting for a clock edge.

## Test plan
- **Stream from reset.** Memory word i = 32'hF840_0000 | i, PC_RESET=0, release reset. Required: `valid_d` rises 2 cycles later, then (`pc_d`, `instr_d`) = (0, F8400000), (4, F8400001), (8, F8400002) on consecutive cycles.
- **Stall.** Hold `stall_d` for 3 cycles while `pc_d`=8. Required: `pc_d` stays 8, `imem_en` is 0 on all 3 cycles, and after release the outputs are pc 12, then 16, with none lost or duplicated.
- **Redirect.** Pulse `redirect` with `redirect_pc`=64'h23 while streaming. Required: `valid_d` drops for 1 cycle, then `pc_d`=0x20 (`instr_d`=F8400008), then 0x24.
- **Redirect during stall.** Assert `redirect` to 0x40 inside a stall. Required: `valid_d`=0 next edge. After the stall releases, `pc_d`=0x40 appears, and the stale held instruction never appears.
- **Async reset.** Pull `reset` low between clock edges. Required: `valid_d`=0, `pc_d`=0 and `imem_en`=0 immediately, and the stream restarts at PC_RESET.
- **Wrap-around.** Set PC_RESET=64'hFFFF_FFFF_FFFF_FFFC. Required: `pc_d` sequence is ...FFFC then 0, with `imem_addr` wrapping from 2^ADDR_W−1 to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC, synchronous-read imem request and IF/ID register.
// A one-entry hold buffer catches the in-flight response when decode stalls.
module fetch_stage #(
  parameter logic [63:0] PC_RESET = 64'h0,
  parameter int          ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall_d,
  input  logic              redirect,
  input  logic [63:0]       redirect_pc,
  output logic [31:0]       instr_d,
  output logic [63:0]       pc_d,
  output logic              valid_d
);

  // Handshake: a request is issued whenever decode can take a new instruction
  // (stall_d low) or a redirect forces a refetch; its data returns one cycle
  // later. stall_d freezes IF/ID; redirect flushes IF/ID and the hold buffer
  // and overrides stall_d.
  logic        w_issue;
  logic [63:0] w_fetch_pc;
  logic        w_unused;

  logic [63:0] r_pc_f;
  logic        r_req_valid;
  logic [63:0] r_req_pc;
  logic        r_hold_valid;
  logic [31:0] r_hold_instr;
  logic [63:0] r_hold_pc;
  logic        r_valid_d;
  logic [31:0] r_instr_d;
  logic [63:0] r_pc_d;

  assign w_issue    = reset & (redirect | ~stall_d);
  assign w_fetch_pc = redirect ? {redirect_pc[63:2], 2'b00} : r_pc_f;
  assign w_unused   = ^redirect_pc[1:0];

  assign imem_en   = w_issue;
  assign imem_addr = w_fetch_pc[ADDR_W+1:2];
  assign instr_d   = r_instr_d;
  assign pc_d      = r_pc_d;
  assign valid_d   = r_valid_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_f       <= PC_RESET;
      r_req_valid  <= 1'b0;
      r_req_pc     <= 64'h0;
      r_hold_valid <= 1'b0;
      r_hold_instr <= 32'h0;
      r_hold_pc    <= 64'h0;
      r_valid_d    <= 1'b0;
      r_instr_d    <= 32'h0;
      r_pc_d       <= 64'h0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_pc <= w_fetch_pc;
        r_pc_f   <= w_fetch_pc + 64'd4;
      end
      if (redirect) begin
        // Response returning this cycle belongs to the wrong path: drop it.
        r_valid_d    <= 1'b0;
        r_hold_valid <= 1'b0;
      end else if (stall_d) begin
        if (r_req_valid && !r_hold_valid) begin
          r_hold_instr <= imem_rdata;
          r_hold_pc    <= r_req_pc;
          r_hold_valid <= 1'b1;
        end
      end else if (r_hold_valid) begin
        r_valid_d    <= 1'b1;
        r_instr_d    <= r_hold_instr;
        r_pc_d       <= r_hold_pc;
        r_hold_valid <= 1'b0;
      end else begin
        r_valid_d <= r_req_valid;
        r_instr_d <= r_req_valid ? imem_rdata : 32'h0;
        r_pc_d    <= r_req_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect traffic
// checked against a queue-based model of fetched-but-undelivered instructions.
module tb_fetch_stage;
  localparam int          ADDR_W  = 6;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, stall_d, redirect;
  logic [63:0]       redirect_pc;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata, instr_d;
  logic [63:0]       pc_d;
  logic              valid_d;

  logic              reset2, imem_en2, valid_d2;
  logic [ADDR_W-1:0] imem_addr2;
  logic [31:0]       imem_rdata2, instr_d2;
  logic [63:0]       pc_d2;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(.PC_RESET(64'h0), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall_d(stall_d), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d)
  );

  fetch_stage #(.PC_RESET(WRAP_PC), .ADDR_W(ADDR_W)) dut_wrap (
    .clk(clk), .reset(reset2), .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .stall_d(1'b0), .redirect(1'b0),
    .redirect_pc(64'h0), .instr_d(instr_d2), .pc_d(pc_d2), .valid_d(valid_d2)
  );

  // Synchronous-read memories; garbage on idle cycles exposes unrequested reads.
  always @(posedge clk) imem_rdata  <= imem_en  ? mem[imem_addr]  : $urandom;
  always @(posedge clk) imem_rdata2 <= imem_en2 ? mem[imem_addr2] : $urandom;

  always @(negedge clk) begin
    if (reset && dut.r_req_valid && dut.r_hold_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL hold_invariant: response in flight with hold buffer full at %0t", $time);
    end
  end

  // Reference model state
  logic [63:0]       exp_q[$];
  logic [63:0]       m_pc, m_pc_d;
  logic              m_valid;
  logic [31:0]       m_instr;
  logic              exp_en, obs_en;
  logic [ADDR_W-1:0] exp_addr, obs_addr;

  task automatic model_reset();
    exp_q.delete();
    m_pc    = 64'h0;
    m_valid = 1'b0;
  endtask

  // One clock cycle: drive at negedge, sample comb outputs, advance model,
  // return #1 after the rising edge.
  task automatic cycle(input logic st, input logic rd, input logic [63:0] rpc);
    logic [63:0] fpc, p;
    @(negedge clk);
    stall_d = st; redirect = rd; redirect_pc = rpc;
    #1;
    obs_en = imem_en; obs_addr = imem_addr;
    exp_en = reset && (rd || !st);
    fpc = rd ? {rpc[63:2], 2'b00} : m_pc;
    exp_addr = fpc[ADDR_W+1:2];
    if (rd) begin
      exp_q.delete();
      m_valid = 1'b0;
    end else if (!st) begin
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        m_valid = 1'b1; m_pc_d = p; m_instr = mem[p[ADDR_W+1:2]];
      end else begin
        m_valid = 1'b0;
      end
    end
    if (exp_en) begin
      exp_q.push_back(fpc);
      m_pc = fpc + 64'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; reset2 = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (valid_d !== 1'b0 || pc_d !== 64'h0 || instr_d !== 32'h0 || imem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b pc=%h ins=%h en=%0b want 0/0/0/0", valid_d, pc_d, instr_d, imem_en);
    end
  endtask

  task automatic test_stream();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 64'h0);
      n_tests++;
      if (obs_en !== 1'b1 || obs_addr !== ADDR_W'(k)) begin
        n_fail++;
        $display("FAIL stream_req%0d: got en=%0b addr=%0d want 1/%0d", k, obs_en, obs_addr, k);
      end
      n_tests++;
      if (k == 0 && valid_d !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_latency: got valid_d=%0b want 0", valid_d);
      end else if (k > 0 && (valid_d !== 1'b1 || pc_d !== 64'(4*(k-1)) || instr_d !== (32'hF840_0000 | 32'(k-1)))) begin
        n_fail++;
        $display("FAIL stream_out%0d: got v=%0b pc=%h ins=%h want 1/%h/%h", k, valid_d, pc_d, instr_d, 64'(4*(k-1)), 32'hF840_0000 | 32'(k-1));
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 64'h0);
      n_tests++;
      if (obs_en !== 1'b0 || valid_d !== 1'b1 || pc_d !== 64'h8 || instr_d !== 32'hF840_0002) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got en=%0b v=%0b pc=%h ins=%h want 0/1/8/f8400002", k, obs_en, valid_d, pc_d, instr_d);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 64'h0);
      n_tests++;
      if (valid_d !== 1'b1 || pc_d !== 64'(12 + 4*k) || instr_d !== (32'hF840_0003 + 32'(k))) begin
        n_fail++;
        $display("FAIL stall_release%0d: got v=%0b pc=%h ins=%h want 1/%h", k, valid_d, pc_d, instr_d, 64'(12 + 4*k));
      end
    end
  endtask

  task automatic test_redirect();
    cycle(1'b0, 1'b1, 64'h23);
    n_tests++;
    if (valid_d !== 1'b0 || obs_en !== 1'b1 || obs_addr !== ADDR_W'(8)) begin
      n_fail++;
      $display("FAIL redirect_flush: got v=%0b en=%0b addr=%0d want 0/1/8", valid_d, obs_en, obs_addr);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 64'h0);
      n_tests++;
      if (valid_d !== 1'b1 || pc_d !== 64'(32 + 4*k) || instr_d !== (32'hF840_0008 + 32'(k))) begin
        n_fail++;
        $display("FAIL redirect_target%0d: got v=%0b pc=%h ins=%h want 1/%h", k, valid_d, pc_d, instr_d, 64'(32 + 4*k));
      end
    end
  endtask

  task automatic test_redirect_stall();
    cycle(1'b1, 1'b0, 64'h0);
    cycle(1'b1, 1'b1, 64'h40);
    n_tests++;
    if (valid_d !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_stall_flush: got valid_d=%0b want 0", valid_d);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b0, 64'h0);
      n_tests++;
      if (valid_d !== 1'b0 || obs_en !== 1'b0) begin
        n_fail++;
        $display("FAIL redir_stall_wait%0d: got v=%0b en=%0b want 0/0", k, valid_d, obs_en);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 64'h0);
      n_tests++;
      if (valid_d !== 1'b1 || pc_d !== 64'(64 + 4*k) || instr_d !== (32'hF840_0010 + 32'(k))) begin
        n_fail++;
        $display("FAIL redir_stall_target%0d: got v=%0b pc=%h ins=%h want 1/%h", k, valid_d, pc_d, instr_d, 64'(64 + 4*k));
      end
    end
  endtask

  task automatic test_random();
    logic st, rd;
    logic [63:0] rpc;
    for (int n = 0; n < 400; n++) begin
      st  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = {$urandom, $urandom};
      cycle(st, rd, rpc);
      n_tests++;
      if (obs_en !== exp_en || (exp_en && obs_addr !== exp_addr)) begin
        n_fail++;
        $display("FAIL rand_req%0d: got en=%0b addr=%0d want %0b/%0d", n, obs_en, obs_addr, exp_en, exp_addr);
      end
      n_tests++;
      if (valid_d !== m_valid || (m_valid && (pc_d !== m_pc_d || instr_d !== m_instr))) begin
        n_fail++;
        $display("FAIL rand_out%0d: got v=%0b pc=%h ins=%h want %0b/%h/%h", n, valid_d, pc_d, instr_d, m_valid, m_pc_d, m_instr);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 64'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (valid_d !== 1'b0 || pc_d !== 64'h0 || imem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%0b pc=%h en=%0b want 0/0/0", valid_d, pc_d, imem_en);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 64'h0);
      n_tests++;
      if (valid_d !== m_valid || (m_valid && (pc_d !== m_pc_d || instr_d !== m_instr)) ||
          (k == 1 && pc_d !== 64'h0)) begin
        n_fail++;
        $display("FAIL restart%0d: got v=%0b pc=%h ins=%h want %0b/%h/%h", k, valid_d, pc_d, instr_d, m_valid, m_pc_d, m_instr);
      end
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] ea;
    logic [63:0]       epc;
    logic [31:0]       ein;
    reset2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      ea = ADDR_W'((1 << ADDR_W) - 1 + k);
      n_tests++;
      if (imem_en2 !== 1'b1 || imem_addr2 !== ea) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: got en=%0b addr=%0d want 1/%0d", k, imem_en2, imem_addr2, ea);
      end
      @(posedge clk); #1;
      if (k > 0) begin
        epc = WRAP_PC + 64'(4*(k-1));
        ein = mem[ADDR_W'((1 << ADDR_W) - 2 + k)];
        n_tests++;
        if (valid_d2 !== 1'b1 || pc_d2 !== epc || instr_d2 !== ein) begin
          n_fail++;
          $display("FAIL wrap_out%0d: got v=%0b pc=%h ins=%h want 1/%h/%h", k, valid_d2, pc_d2, instr_d2, epc, ein);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hF840_0000 | 32'(i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_random();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
